// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and helpers for the four-client round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arb_pick_4.sv
// Rotating-priority pick: the client just after 'last' is favoured, 'last' itself comes last.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  pick_id,
    output logic             pick_valid
);

    logic [ID_W-1:0]  offset;
    logic [N_REQ-1:0] req_rot;
    logic [ID_W-1:0]  enc;

    assign offset = last + 1'b1;

    // Rotate right by offset so the highest-priority client lands on bit 0.
    always_comb begin
        req_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rot[i] = req[ID_W'(i) + offset];
        end
    end

    always_comb begin
        enc = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                enc = ID_W'(i);
            end
        end
    end

    assign pick_valid = |req;
    assign pick_id    = enc + offset;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter with registered one-hot grant, hold limit and a
// mandatory one-cycle bubble after every release.
module rr_arbiter_4
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid
);

    localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_LIMITED ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_MAX    = '1;

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;
    logic              release_now;

    rr_pick_4 u_pick (
        .req        (req),
        .last       (last_q),
        .pick_id    (pick_id),
        .pick_valid (pick_valid)
    );

    assign release_now = !req[gnt_id_q] || (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST));

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_GRANT;
                    gnt_d      = id_to_onehot(pick_id);
                    gnt_id_d   = pick_id;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    // gnt_id is kept so the last winner stays visible; only gnt_valid qualifies it.
                    state_d    = ST_IDLE;
                    gnt_d      = '0;
                    last_d     = gnt_id_q;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4: one instance with MAX_HOLD=8, one with unlimited hold.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req, req_u;
    logic [3:0] gnt, gnt_u;
    logic [1:0] gnt_id, gnt_id_u;
    logic       gnt_valid, gnt_valid_u;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] g;
        logic [3:0] g_u;
        int         hold_u;
    } exp_t;

    exp_t sb[$];

    rr_arbiter_4 #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    rr_arbiter_4 #(.MAX_HOLD(0), .HOLD_W(4)) dut_u (
        .clk       (clk),
        .rst       (rst),
        .req       (req_u),
        .gnt       (gnt_u),
        .gnt_id    (gnt_id_u),
        .gnt_valid (gnt_valid_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh_idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue what must appear after the next rise.
    task automatic drive(input logic r_v, input logic [3:0] rq, input logic [3:0] rq_u,
                         input logic [3:0] eg, input logic [3:0] eg_u, input int eh);
        exp_t e;
        @(negedge clk);
        rst   = r_v;
        req   = rq;
        req_u = rq_u;
        e.g      = eg;
        e.g_u    = eg_u;
        e.hold_u = eh;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("gnt", 32'(gnt), 32'(e.g));
                chk("gnt_valid", 32'(gnt_valid), 32'(|e.g));
                if (e.g != 4'b0) chk("gnt_id", 32'(gnt_id), 32'(oh_idx(e.g)));
                chk("gnt_u", 32'(gnt_u), 32'(e.g_u));
                if (e.g_u != 4'b0) chk("gnt_id_u", 32'(gnt_id_u), 32'(oh_idx(e.g_u)));
                if (e.hold_u >= 0) chk("hold_cnt_u", 32'(dut_u.hold_cnt_q), 32'(e.hold_u));
            end
        end
    end

    initial begin : stim
        int p;
        rst   = 1'b1;
        req   = 4'b1111;
        req_u = 4'b0000;

        // Reset held for two cycles with all clients requesting.
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);

        // Saturation: two full 36-cycle periods.
        for (int k = 0; k < 72; k++) begin
            p = k % 36;
            drive(1'b0, 4'b1111, 4'b0000, ((p % 9) < 8) ? (4'b0001 << (p / 9)) : 4'b0000, 4'b0000, -1);
        end

        // Mid-grant asynchronous reset.
        drive(1'b0, 4'b1111, 4'b0000, 4'b0001, 4'b0000, -1);
        @(posedge clk);
        #3;
        chk("pre_rst_gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'h0);
        chk("async_rst_valid", 32'(gnt_valid), 32'h0);
        drive(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);

        // Single client 2, dropped after four grant cycles.
        for (int k = 0; k < 4; k++) drive(1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0000, -1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1);

        // Early release of client 0, then client 1 after the bubble.
        for (int k = 0; k < 3; k++) drive(1'b0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, -1);
        drive(1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, -1);
        for (int k = 0; k < 3; k++) drive(1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000, -1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1);

        // Rotation: client 3, others ignored mid-grant, then 0 wins, then 3 wins again.
        drive(1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, -1);
        drive(1'b0, 4'b1111, 4'b0000, 4'b1000, 4'b0000, -1);
        drive(1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, -1);
        drive(1'b0, 4'b1001, 4'b0000, 4'b0001, 4'b0000, -1);
        drive(1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, -1);
        drive(1'b0, 4'b1001, 4'b0000, 4'b1000, 4'b0000, -1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1);

        // Unlimited hold: client 0 keeps the grant for 100 cycles, counter saturates at 15.
        for (int k = 0; k < 100; k++) drive(1'b0, 4'b0000, 4'b0011, 4'b0000, 4'b0001, (k < 15) ? k : 15);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

        @(posedge clk);
        #2;
        if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
Four-requester round-robin arbiter that shares a single downstream resource between four clients. A rotating-priority 4-to-2 encode selects the winner, and the grant is registered and held until released. A hold-limit counter prevents any one client from monopolising the resource. The arbiter sits directly in front of the shared datapath and drives its select and enable.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles per winner; 0 = unlimited; must satisfy MAX_HOLD < 2**HOLD_W
HOLD_W, 4, width of the hold counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  4  request vector, bit i = client i; level-sensitive
gnt  output  4  one-hot grant, registered; all-zero when no grant
gnt_id  output  2  binary index of the granted client; valid only while gnt_valid=1
gnt_valid  output  1  high while any grant is active (equals OR of gnt)

Behaviour:
- Clocking: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst: gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, state=IDLE, hold_cnt=0, last=2'd3. last=3 gives client 0 top priority first.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at a rising edge, the winner is the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - After that edge: gnt=onehot(winner), gnt_id=winner, gnt_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled to gnt is 1 cycle.
  - If req==0, remain in IDLE with outputs at 0.
- GRANT, evaluated at each rising edge:
  - Release when req[gnt_id]==0, or when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - On release: gnt=0, gnt_valid=0, last=gnt_id, hold_cnt=0, state=IDLE.
  - Otherwise hold_cnt increments by 1. hold_cnt saturates when MAX_HOLD=0; it never wraps.
- Dead cycle: every release is followed by exactly one cycle with gnt=0. The next arbitration happens at the following edge. The downstream datapath relies on this bubble for turnaround.
- Hold limit: a continuously requesting client receives exactly MAX_HOLD grant cycles. It is then placed lowest priority.
- Mid-grant requests: new requests from other clients during GRANT are ignored until the next IDLE. Request bits are not latched; a request dropped before arbitration is lost.
- A client dropping and re-raising req during the dead cycle competes normally. Because last was just updated to that client, it has lowest priority.
- req bit toggling while not granted has no effect on state.
- gnt is always one-hot or zero. Two bits set is a fatal assertion.
- gnt_id holds its last value in IDLE, but is only meaningful with gnt_valid.
- Reset mid-GRANT drops gnt asynchronously. The pointer returns to last=3, so no fairness history is kept across reset.

Decomposition:
- Shared package rr_arb_pkg:
  - localparam N_REQ=4, ID_W=2
  - state encoding ST_IDLE=1'b0, ST_GRANT=1'b1
- One combinational sub-module, rr_pick_4:
  - Inputs: req[3:0], last[1:0].
  - Outputs: pick_id[1:0], pick_valid.
  - Implementation: rotate req right by last+1, apply the 4-to-2 priority-encode (lowest index wins after rotation), add back the offset mod 4.
- The top level holds the FSM, hold counter and output registers.

Test Plan:
1. Reset: assert rst for 2 cycles with req=4'b1111, then release → gnt=0 during reset; first edge after release gives gnt=4'b0001, gnt_id=0. Assert rst mid-grant → gnt=0 asynchronously, with no clock edge needed.
2. Single client: req=4'b0100 from cycle 0 → gnt=4'b0100, gnt_id=2 from cycle 1. Drop req at cycle 4 → gnt=0 from cycle 5.
3. Saturation: req=4'b1111 constant, MAX_HOLD=8 → gnt sequence is 0001×8, 0000×1, 0010×8, 0000×1, 0100×8, 0000×1, 1000×8, 0000×1, then repeats. Period is 36 cycles, with no client starved.
4. Early release: req=4'b0011, client 0 granted, client 0 drops req after 3 grant cycles → gnt=0001 for 3 cycles, 1 dead cycle, then 0010.
5. Rotation fairness: after client 3 is released (last=3), req=4'b1001 → client 0 wins. After client 0 is released, the same req → client 3 wins.
6. Unlimited hold: MAX_HOLD=0, req=4'b0011 held 100 cycles → gnt=0001 for all 100 cycles with no forced release. hold_cnt saturates at 15 and never wraps.
